frame_bank_scheduler: RTL and testbench

- Parametrised successor to the two-bank read/write mode FSM. Manages NUM_BANKS video frame banks as a ring: the SD/SPI writer fills empty banks while the VGA reader displays full ones.
- Adds prefill before playback, per-frame repeat (frame-rate conversion), underrun detection, and occupancy reporting.
- Sits between DATA_FSM (start_req/done handshake) and video_top (one-hot read/write bank selects).

---
 rtl/frame_bank_scheduler_if.sv | 36 +++
 rtl/frame_bank_scheduler.sv | 140 ++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_bank_scheduler_if.sv
// Handshake/bank-select bundle between DATA_FSM/VGA timing (master) and frame_bank_scheduler (slave).
// Optional macro UNDERRUN_CNT_EN adds the underrun_cnt signal.
interface frame_bank_scheduler_if #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_BANKS)
);
  logic                 init;
  logic                 wr_done;
  logic                 frame_end;
  logic                 start_req;
  logic [NUM_BANKS-1:0] wr_bank;
  logic [NUM_BANKS-1:0] rd_bank;
  logic                 rd_valid;
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W:0]       fill_level;
  logic                 underrun;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]          underrun_cnt;
`endif

  modport master (
    output init, wr_done, frame_end,
`ifdef UNDERRUN_CNT_EN
    input  underrun_cnt,
`endif
    input  start_req, wr_bank, rd_bank, rd_valid, rd_idx, fill_level, underrun
  );

  modport slave (
    input  init, wr_done, frame_end,
`ifdef UNDERRUN_CNT_EN
    output underrun_cnt,
`endif
    output start_req, wr_bank, rd_bank, rd_valid, rd_idx, fill_level, underrun
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Ring of NUM_BANKS frame banks: writer fills empty banks, VGA reader shows full ones with
// prefill, per-frame repeat and sticky underrun. Optional macro UNDERRUN_CNT_EN adds underrun_cnt.
module frame_bank_scheduler #(
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned PREFILL_BANKS = 2,
  parameter int unsigned FRAME_REPEAT  = 2,
  parameter int unsigned IDX_W         = $clog2(NUM_BANKS)
) (
  input logic                   CLK_40,
  input logic                   reset,
  frame_bank_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPrefill, StPlay} state_e;

  state_e               state_q, state_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [7:0]           rep_q, rep_d;
  logic                 pend_q, pend_d;
  logic                 start_q, start_d;
  logic [IDX_W:0]       fill_q, fill_d;
  logic                 under_q, under_d;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]          ucnt_q, ucnt_d;
`endif

  logic                 wr_fire;
  logic                 release_bank;
  logic [IDX_W-1:0]     rd_next;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_BANKS - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    rep_d        = rep_q;
    pend_d       = pend_q;
    start_d      = 1'b0;
    under_d      = under_q;
`ifdef UNDERRUN_CNT_EN
    ucnt_d       = ucnt_q;
`endif
    release_bank = 1'b0;
    rd_next      = inc_idx(rd_idx_q);
    wr_fire      = pend_q && bus.wr_done && (state_q != StIdle);

    case (state_q)
      StIdle:    if (bus.init) state_d = StPrefill;
      StPrefill: if (fill_q >= (IDX_W+1)'(PREFILL_BANKS)) state_d = StPlay;
      StPlay:    state_d = StPlay;
      default:   state_d = StIdle;
    endcase

    // Write engine: one outstanding write at a time, only into an empty bank.
    if (state_q != StIdle) begin
      if (wr_fire) begin
        full_d[wr_idx_q] = 1'b1;
        pend_d           = 1'b0;
        wr_idx_d         = inc_idx(wr_idx_q);
      end else if (!pend_q && !full_q[wr_idx_q]) begin
        start_d = 1'b1;
        pend_d  = 1'b1;
      end
    end

    // Read engine; a completing write into the next bank counts as full (bypass).
    if (state_q == StPlay && bus.frame_end) begin
      if (rep_q < 8'(FRAME_REPEAT - 1)) begin
        rep_d = rep_q + 8'd1;
      end else if (full_q[rd_next] || (wr_fire && wr_idx_q == rd_next)) begin
        full_d[rd_idx_q] = 1'b0;
        rd_idx_d         = rd_next;
        rep_d            = 8'd0;
        release_bank     = 1'b1;
      end else begin
        under_d = 1'b1;
`ifdef UNDERRUN_CNT_EN
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`endif
      end
    end

    case ({wr_fire, release_bank})
      2'b10:   fill_d = fill_q + (IDX_W+1)'(1);
      2'b01:   fill_d = fill_q - (IDX_W+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (!reset) begin
      state_q  <= StIdle;
      full_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      rep_q    <= '0;
      pend_q   <= 1'b0;
      start_q  <= 1'b0;
      fill_q   <= '0;
      under_q  <= 1'b0;
`ifdef UNDERRUN_CNT_EN
      ucnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      rep_q    <= rep_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      fill_q   <= fill_d;
      under_q  <= under_d;
`ifdef UNDERRUN_CNT_EN
      ucnt_q   <= ucnt_d;
`endif
    end
  end

  assign bus.start_req  = start_q;
  assign bus.wr_bank    = pend_q ? (NUM_BANKS'(1) << wr_idx_q) : '0;
  assign bus.rd_valid   = (state_q == StPlay);
  assign bus.rd_bank    = (state_q == StPlay) ? (NUM_BANKS'(1) << rd_idx_q) : '0;
  assign bus.rd_idx     = rd_idx_q;
  assign bus.fill_level = fill_q;
  assign bus.underrun   = under_q;
`ifdef UNDERRUN_CNT_EN
  assign bus.underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: two instances (4 banks/repeat 2 and 3 banks/repeat 1) checked
// every cycle against a bank-ring model, plus directed literal expectations and random traffic.
module tb_frame_bank_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n   = 2'b00;
  logic [1:0] init_v  = 2'b00;
  logic [1:0] fe_v    = 2'b00;
  logic [1:0] man_wd  = 2'b00;
  logic [1:0] resp_wd = 2'b00;
  bit   [1:0] auto_wr = 2'b00;
  int         dly_fixed [2] = '{0, 3};
  int         cd [2] = '{0, 0};

  frame_bank_scheduler_if #(.NUM_BANKS(4)) bus_a ();
  frame_bank_scheduler_if #(.NUM_BANKS(3)) bus_b ();

  assign bus_a.init      = init_v[0];
  assign bus_a.wr_done   = man_wd[0] | resp_wd[0];
  assign bus_a.frame_end = fe_v[0];
  assign bus_b.init      = init_v[1];
  assign bus_b.wr_done   = man_wd[1] | resp_wd[1];
  assign bus_b.frame_end = fe_v[1];

  frame_bank_scheduler #(.NUM_BANKS(4), .PREFILL_BANKS(2), .FRAME_REPEAT(2)) dut_a (
    .CLK_40 (clk),
    .reset  (rst_n[0]),
    .bus    (bus_a)
  );

  frame_bank_scheduler #(.NUM_BANKS(3), .PREFILL_BANKS(2), .FRAME_REPEAT(1)) dut_b (
    .CLK_40 (clk),
    .reset  (rst_n[1]),
    .bus    (bus_b)
  );

  localparam int SStart = 0, SWrBank = 1, SRdValid = 2, SRdBank = 3, SRdIdx = 4, SFill = 5,
                 SUnder = 6, SUcnt = 7;
`ifdef UNDERRUN_CNT_EN
  localparam int NSel = 8;
`else
  localparam int NSel = 7;
`endif

  function automatic string sel_name(input int sel);
    case (sel)
      SStart:   return "start_req";
      SWrBank:  return "wr_bank";
      SRdValid: return "rd_valid";
      SRdBank:  return "rd_bank";
      SRdIdx:   return "rd_idx";
      SFill:    return "fill_level";
      SUnder:   return "underrun";
      default:  return "underrun_cnt";
    endcase
  endfunction

  function automatic longint dut_sig(input int k, input int sel);
    if (k == 0) begin
      case (sel)
        SStart:   return longint'(bus_a.start_req);
        SWrBank:  return longint'(bus_a.wr_bank);
        SRdValid: return longint'(bus_a.rd_valid);
        SRdBank:  return longint'(bus_a.rd_bank);
        SRdIdx:   return longint'(bus_a.rd_idx);
        SFill:    return longint'(bus_a.fill_level);
        SUnder:   return longint'(bus_a.underrun);
`ifdef UNDERRUN_CNT_EN
        SUcnt:    return longint'(bus_a.underrun_cnt);
`endif
        default:  return -1;
      endcase
    end
    case (sel)
      SStart:   return longint'(bus_b.start_req);
      SWrBank:  return longint'(bus_b.wr_bank);
      SRdValid: return longint'(bus_b.rd_valid);
      SRdBank:  return longint'(bus_b.rd_bank);
      SRdIdx:   return longint'(bus_b.rd_idx);
      SFill:    return longint'(bus_b.fill_level);
      SUnder:   return longint'(bus_b.underrun);
`ifdef UNDERRUN_CNT_EN
      SUcnt:    return longint'(bus_b.underrun_cnt);
`endif
      default:  return -1;
    endcase
  endfunction

  // Reference model: mode 0 idle, 1 prefill, 2 play; banks as a plain array of full flags.
  int nb [2] = '{4, 3};
  int pb [2] = '{2, 2};
  int fr [2] = '{2, 1};
  int m_mode [2], m_wr [2], m_rd [2], m_rep [2], m_ucnt [2];
  bit m_pend [2], m_under [2], m_start [2], m_live [2];
  bit m_full [2][16];

  function automatic int full_count(input int k);
    int c = 0;
    for (int i = 0; i < nb[k]; i++) c += int'(m_full[k][i]);
    return c;
  endfunction

  function automatic longint model_sig(input int k, input int sel);
    case (sel)
      SStart:   return longint'(m_start[k]);
      SWrBank:  return m_pend[k] ? (longint'(1) << m_wr[k]) : 0;
      SRdValid: return longint'(m_mode[k] == 2);
      SRdBank:  return (m_mode[k] == 2) ? (longint'(1) << m_rd[k]) : 0;
      SRdIdx:   return longint'(m_rd[k]);
      SFill:    return longint'(full_count(k));
      SUnder:   return longint'(m_under[k]);
      default:  return longint'(m_ucnt[k]);
    endcase
  endfunction

  task automatic model_step(input int k);
    int n, nxt, old_wr, old_rd, fl;
    bit wd, done, rel;
    n  = nb[k];
    wd = man_wd[k] | resp_wd[k];
    m_live[k] = 1'b1;
    if (!rst_n[k]) begin
      m_mode[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_rep[k] = 0; m_ucnt[k] = 0;
      m_pend[k] = 0; m_under[k] = 0; m_start[k] = 0;
      for (int i = 0; i < 16; i++) m_full[k][i] = 1'b0;
      return;
    end
    fl = full_count(k);
    old_wr = m_wr[k];
    old_rd = m_rd[k];
    nxt = (old_rd + 1) % n;
    done = 0;
    rel = 0;
    m_start[k] = 0;
    if (m_mode[k] != 0) begin
      if (m_pend[k] && wd) done = 1;
      else if (!m_pend[k] && !m_full[k][old_wr]) begin
        m_start[k] = 1;
        m_pend[k]  = 1;
      end
    end
    if (m_mode[k] == 2 && fe_v[k]) begin
      if (m_rep[k] < fr[k] - 1) m_rep[k]++;
      else if (m_full[k][nxt] || (done && old_wr == nxt)) rel = 1;
      else begin
        m_under[k] = 1;
        if (m_ucnt[k] < 65535) m_ucnt[k]++;
      end
    end
    if (done) begin
      m_full[k][old_wr] = 1;
      m_pend[k] = 0;
      m_wr[k] = (old_wr + 1) % n;
    end
    if (rel) begin
      m_full[k][old_rd] = 0;
      m_rd[k] = nxt;
      m_rep[k] = 0;
    end
    if (m_mode[k] == 1 && fl >= pb[k]) m_mode[k] = 2;
    if (m_mode[k] == 0 && init_v[k]) m_mode[k] = 1;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Auto writer: answers each start_req with wr_done after a fixed or random delay.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      resp_wd[k] = 1'b0;
      if (auto_wr[k]) begin
        if (cd[k] > 0) begin
          cd[k]--;
          if (cd[k] == 0) resp_wd[k] = 1'b1;
        end
        if (dut_sig(k, SStart) == 1)
          cd[k] = (dly_fixed[k] > 0) ? dly_fixed[k] : int'($urandom_range(1, 12));
      end else begin
        cd[k] = 0;
      end
    end
  end

  // Literal expectations queued by the stimulus, evaluated by the compare process.
  int     lit_k [512];
  int     lit_sel [512];
  longint lit_exp [512];
  int     lit_wr = 0;

  task automatic push(input int k, input int sel, input longint e);
    if (lit_wr < 512) begin
      lit_k[lit_wr]   = k;
      lit_sel[lit_wr] = sel;
      lit_exp[lit_wr] = e;
      lit_wr++;
    end
  endtask

  int n_checks = 0;
  int n_fail   = 0;
  int lit_rd   = 0;

  task automatic check(input string tag, input int k, input int sel, input longint act,
                       input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s %s dut%0d @%0t: actual %0d, required %0d", tag, sel_name(sel), k,
               $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_live[k]) begin
        for (int s = 0; s < NSel; s++) check("model", k, s, dut_sig(k, s), model_sig(k, s));
      end
    end
    while (lit_rd < lit_wr) begin
      check("literal", lit_k[lit_rd], lit_sel[lit_rd], dut_sig(lit_k[lit_rd], lit_sel[lit_rd]),
            lit_exp[lit_rd]);
      check("model-pin", lit_k[lit_rd], lit_sel[lit_rd],
            model_sig(lit_k[lit_rd], lit_sel[lit_rd]), lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sig(input int k, input int sel, input longint v, input int lim);
    int i = 0;
    while (dut_sig(k, sel) != v && i < lim) begin
      tick();
      i++;
    end
    push(k, sel, v);
  endtask

  task automatic pulse_fe(input int k);
    fe_v[k] = 1'b1;
    tick();
    fe_v[k] = 1'b0;
  endtask

  task automatic pulse_wd(input int k);
    man_wd[k] = 1'b1;
    tick();
    man_wd[k] = 1'b0;
  endtask

  int exp_b [7] = '{1, 2, 0, 1, 2, 0, 1};

  initial begin
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      push(k, SStart, 0); push(k, SWrBank, 0); push(k, SRdValid, 0); push(k, SFill, 0);
    end
    rst_n = 2'b11;

    // Prefill with a 10-cycle writer.
    init_v[0] = 1'b1;
    tick();
    init_v[0] = 1'b0;
    wait_sig(0, SStart, 1, 8);
    push(0, SWrBank, 1);
    repeat (9) tick();
    pulse_wd(0);
    wait_sig(0, SStart, 1, 8);
    push(0, SWrBank, 2);
    repeat (9) tick();
    pulse_wd(0);
    push(0, SRdValid, 0); push(0, SFill, 2);
    tick();
    push(0, SRdValid, 1); push(0, SRdBank, 1); push(0, SFill, 2);

    // Fill the rest of the ring; it then stalls.
    wait_sig(0, SStart, 1, 8);
    push(0, SWrBank, 4);
    tick(); pulse_wd(0);
    wait_sig(0, SStart, 1, 8);
    push(0, SWrBank, 8);
    tick(); pulse_wd(0);
    repeat (4) tick();
    push(0, SFill, 4); push(0, SStart, 0); push(0, SWrBank, 0);

    // Two frames per bank, then release of bank 0 and a refill request for it.
    pulse_fe(0);
    push(0, SRdIdx, 0);
    pulse_fe(0);
    push(0, SRdIdx, 1); push(0, SFill, 3); push(0, SStart, 0);
    tick();
    push(0, SStart, 1); push(0, SWrBank, 1);

    // Writer stalls on bank 0: drain to bank 3, then underrun.
    repeat (4) pulse_fe(0);
    push(0, SRdIdx, 3); push(0, SFill, 1); push(0, SUnder, 0);
    pulse_fe(0);
    pulse_fe(0);
    push(0, SUnder, 1); push(0, SRdIdx, 3);
`ifdef UNDERRUN_CNT_EN
    push(0, SUcnt, 1);
`endif
    pulse_fe(0);
    push(0, SRdIdx, 3);
`ifdef UNDERRUN_CNT_EN
    push(0, SUcnt, 2);
`endif

    // Reset in the middle of an outstanding write.
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    for (int s = 0; s < NSel; s++) push(0, s, 0);
    pulse_wd(0);
    repeat (6) begin
      tick();
      push(0, SStart, 0);
    end
    push(0, SFill, 0);

    // Bypass: wr_done into the next bank coincides with the due advance.
    init_v[0] = 1'b1;
    tick();
    init_v[0] = 1'b0;
    wait_sig(0, SStart, 1, 8);
    tick(); pulse_wd(0);
    wait_sig(0, SStart, 1, 8);
    tick(); pulse_wd(0);
    tick();
    push(0, SRdValid, 1);
    pulse_fe(0);
    pulse_fe(0);
    push(0, SRdIdx, 1); push(0, SFill, 1);
    pulse_fe(0);
    fe_v[0] = 1'b1;
    man_wd[0] = 1'b1;
    tick();
    fe_v[0] = 1'b0;
    man_wd[0] = 1'b0;
    push(0, SRdIdx, 2); push(0, SUnder, 0); push(0, SFill, 1);

    // Three banks, one frame per bank, writer keeping up.
    auto_wr[1] = 1'b1;
    init_v[1] = 1'b1;
    tick();
    init_v[1] = 1'b0;
    wait_sig(1, SRdValid, 1, 60);
    wait_sig(1, SFill, 3, 40);
    repeat (2) tick();
    push(1, SStart, 0);
    pulse_wd(1);
    push(1, SFill, 3);
    tick();
    push(1, SStart, 0); push(1, SWrBank, 0); push(1, SFill, 3);
    for (int i = 0; i < 7; i++) begin
      pulse_fe(1);
      push(1, SRdIdx, exp_b[i]);
      repeat (10) tick();
    end
    push(1, SUnder, 0);

    // Random traffic on both instances.
    rst_n = 2'b00;
    tick();
    rst_n = 2'b11;
    dly_fixed[0] = 0;
    dly_fixed[1] = 0;
    auto_wr = 2'b11;
    init_v = 2'b11;
    tick();
    init_v = 2'b00;
    repeat (4000) begin
      for (int k = 0; k < 2; k++) begin
        fe_v[k]   = ($urandom % 6) == 0;
        man_wd[k] = ($urandom % 40) == 0;
        init_v[k] = ($urandom % 40) == 0;
        rst_n[k]  = ($urandom % 800) != 0;
      end
      tick();
    end
    fe_v = 2'b00;
    man_wd = 2'b00;
    init_v = 2'b00;
    rst_n = 2'b11;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
